// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions for the init, KSA and PRGA stages.
//   ARC4_MEM_DEPTH : entries in the S, ct and pt memories
//   ARC4_BYTE_W    : data/address width of every ARC4 memory
//   prga_state_t   : state encoding of the PRGA controller
package arc4_pkg;

  localparam int unsigned ARC4_MEM_DEPTH = 256;
  localparam int unsigned ARC4_BYTE_W    = 8;

  typedef logic [ARC4_BYTE_W-1:0] arc4_byte_t;

  typedef enum logic [3:0] {
    StIdle,
    StLenA,
    StLenD,
    StRdI,
    StRdJ,
    StWrI,
    StWrJ,
    StRdP,
    StWrP,
    StDone
  } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage. Walks the length-prefixed ciphertext
// memory, keeps permuting S and writes the length-prefixed plaintext memory.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   en / rdy          : start request / idle indication
//   s_addr, s_rddata, s_wrdata, s_wren : S memory port (sync read, 1-cycle latency)
//   ct_addr, ct_rddata                 : ciphertext memory read port
//   pt_addr, pt_wrdata, pt_wren        : plaintext memory write port
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output arc4_byte_t s_addr,
  input  arc4_byte_t s_rddata,
  output arc4_byte_t s_wrdata,
  output logic       s_wren,
  output arc4_byte_t ct_addr,
  input  arc4_byte_t ct_rddata,
  output arc4_byte_t pt_addr,
  output arc4_byte_t pt_wrdata,
  output logic       pt_wren
);

  prga_state_t state_q, state_d;
  arc4_byte_t  i_q, i_d;
  arc4_byte_t  j_q, j_d;
  arc4_byte_t  k_q, k_d;
  arc4_byte_t  len_q, len_d;
  arc4_byte_t  si_q, si_d;
  arc4_byte_t  sj_q, sj_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    unique case (state_q)
      StIdle: begin
        rdy = 1'b1;
        if (en) state_d = StLenA;
      end
      StLenA: begin
        ct_addr = '0;
        state_d = StLenD;
      end
      StLenD: begin
        // Length byte is copied straight through to pt[0].
        len_d     = ct_rddata;
        pt_addr   = '0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        i_d       = 8'd1;
        j_d       = '0;
        k_d       = 8'd1;
        state_d   = (ct_rddata == '0) ? StDone : StRdI;
      end
      StRdI: begin
        s_addr  = i_q;
        state_d = StRdJ;
      end
      StRdJ: begin
        // Address S with the updated j in the same cycle it is computed.
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_d;
        state_d = StWrI;
      end
      StWrI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = StWrJ;
      end
      StWrJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        ct_addr  = k_q;
        state_d  = StRdP;
      end
      StRdP: begin
        // ct_addr is held so ct[k] is still on ct_rddata in WR_P.
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = StWrP;
      end
      StWrP: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        // Compare before incrementing so L=255 never wraps k.
        if (k_q == len_q) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = StRdI;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: table vectors, multi-cycle corner sequences and
// randomized messages checked against an array-based ARC4 PRGA model.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  always #5 clk = ~clk;

  prga dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_addr  (pt_addr),
    .pt_wrdata(pt_wrdata),
    .pt_wren  (pt_wren)
  );

  // Memories, bench-side loader and write counters
  logic [7:0] s_mem[256], ct_mem[256], pt_mem[256];
  logic [7:0] s_init[256], ct_init[256];
  logic [7:0] ms[256], exp_pt[256];
  logic       ld;
  logic [7:0] ld_addr;
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  always @(posedge clk) begin
    if (ld) begin
      s_mem[ld_addr]  <= s_init[ld_addr];
      ct_mem[ld_addr] <= ct_init[ld_addr];
      pt_mem[ld_addr] <= 8'h00;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_cnt      <= s_wr_cnt + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_wr_cnt       <= pt_wr_cnt + 1;
      end
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  typedef struct packed {
    logic            use_key;
    logic [7:0]      len;
    logic [0:9][7:0] ct;
    logic [0:9][7:0] pt;
    logic            has_s;
    logic [7:0]      sa;
    logic [7:0]      sa_v;
    logic [7:0]      sb;
    logic [7:0]      sb_v;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  // Key schedule for a 3-byte key, used only to prepare S.
  task automatic set_ksa(input logic [23:0] key);
    logic [7:0] j, t, kb;
    set_identity();
    j = 8'h00;
    for (int a = 0; a < 256; a++) begin
      kb = key[23 - 8 * (a % 3) -: 8];
      j = j + s_init[a] + kb;
      t = s_init[a];
      s_init[a] = s_init[j];
      s_init[j] = t;
    end
  endtask

  task automatic clear_ct();
    for (int a = 0; a < 256; a++) ct_init[a] = 8'h00;
  endtask

  task automatic load_mems();
    @(negedge clk);
    ld = 1'b1;
    for (int a = 0; a < 256; a++) begin
      ld_addr = 8'(a);
      @(negedge clk);
    end
    ld = 1'b0;
  endtask

  // Reference: plaintext and final S from the algorithm, using int arithmetic mod 256.
  task automatic model(input int len);
    int i, j, t;
    for (int a = 0; a < 256; a++) begin
      ms[a]     = s_init[a];
      exp_pt[a] = 8'h00;
    end
    exp_pt[0] = 8'(len);
    i = 0;
    j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + ms[i]) % 256;
      t = ms[i];
      ms[i] = ms[j];
      ms[j] = 8'(t);
      exp_pt[k] = ct_init[k] ^ ms[(ms[i] + ms[j]) % 256];
    end
  endtask

  task automatic run_dut(input bit hold_en, output int busy, output bit timeout);
    @(negedge clk);
    check("idle before start", rdy, 1);
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_en) en = 1'b0;
    busy = 0;
    timeout = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (rdy) begin
        timeout = 1'b0;
        break;
      end
      busy++;
    end
    en = 1'b0;
  endtask

  // Load, run and compare a message of length len against the model.
  task automatic run_and_check(input int len, input bit hold_en, input string tag);
    int busy, sw0, pw0, nbad_pt, nbad_s;
    bit to;
    load_mems();
    model(len);
    sw0 = s_wr_cnt;
    pw0 = pt_wr_cnt;
    run_dut(hold_en, busy, to);
    check({tag, " timeout"}, to, 0);
    check({tag, " busy cycles"}, busy, 3 + 6 * len);
    check({tag, " S writes"}, s_wr_cnt - sw0, 2 * len);
    check({tag, " pt writes"}, pt_wr_cnt - pw0, len + 1);
    nbad_pt = 0;
    nbad_s  = 0;
    for (int a = 0; a < 256; a++) begin
      if (pt_mem[a] !== exp_pt[a]) nbad_pt++;
      if (s_mem[a] !== ms[a]) nbad_s++;
    end
    check({tag, " pt bytes wrong"}, nbad_pt, 0);
    check({tag, " S entries wrong"}, nbad_s, 0);
  endtask

  initial begin
    int sw0, pw0, len, r;
    logic [7:0] t;

    vecs[0] = '{use_key: 1'b0, len: 8'd1,
                ct: {8'h01, 8'h00, 64'h0},
                pt: {8'h01, 8'h02, 64'h0},
                has_s: 1'b1, sa: 8'd1, sa_v: 8'd1, sb: 8'd2, sb_v: 8'd2};
    vecs[1] = '{use_key: 1'b0, len: 8'd2,
                ct: {8'h02, 8'h00, 8'h00, 56'h0},
                pt: {8'h02, 8'h02, 8'h05, 56'h0},
                has_s: 1'b1, sa: 8'd2, sa_v: 8'd3, sb: 8'd3, sb_v: 8'd2};
    vecs[2] = '{use_key: 1'b1, len: 8'd9,
                ct: {8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3},
                pt: {8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74},
                has_s: 1'b0, sa: 8'd0, sa_v: 8'd0, sb: 8'd0, sb_v: 8'd0};

    rst = 1'b1;
    en = 1'b0;
    ld = 1'b0;
    ld_addr = 8'h00;
    repeat (2) @(negedge clk);
    check("reset rdy", rdy, 1);
    check("reset outputs", {s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren}, 0);
    rst = 1'b0;

    // Table vectors
    for (int v = 0; v < 3; v++) begin
      if (vecs[v].use_key) set_ksa(24'h4B6579);
      else set_identity();
      clear_ct();
      for (int b = 0; b < 10; b++) ct_init[b] = vecs[v].ct[b];
      run_and_check(int'(vecs[v].len), 1'b0, $sformatf("vec%0d", v));
      for (int b = 0; b <= int'(vecs[v].len); b++)
        check($sformatf("vec%0d pt[%0d]", v, b), pt_mem[b], vecs[v].pt[b]);
      if (vecs[v].has_s) begin
        check($sformatf("vec%0d S[%0d]", v, vecs[v].sa), s_mem[vecs[v].sa], vecs[v].sa_v);
        check($sformatf("vec%0d S[%0d]", v, vecs[v].sb), s_mem[vecs[v].sb], vecs[v].sb_v);
      end
    end

    // L=0 with en held high throughout the busy period
    set_identity();
    clear_ct();
    run_and_check(0, 1'b1, "len0");
    check("len0 pt[0]", pt_mem[0], 8'h00);
    pw0 = pt_wr_cnt;
    repeat (4) @(negedge clk);
    check("len0 stays idle", rdy, 1);
    check("len0 no restart", pt_wr_cnt - pw0, 0);

    // Reset during WR_I of byte 1
    set_identity();
    clear_ct();
    ct_init[0] = 8'h02;
    load_mems();
    sw0 = s_wr_cnt;
    pw0 = pt_wr_cnt;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset s_wren in WR_I", s_wren, 1);
    rst = 1'b1;
    #1;
    check("mid-reset rdy", rdy, 1);
    check("mid-reset wren", {s_wren, pt_wren}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post-reset idle", rdy, 1);
    check("post-reset S writes", s_wr_cnt - sw0, 0);
    check("post-reset pt writes", pt_wr_cnt - pw0, 1);
    check("post-reset S[1]", s_mem[1], 8'h01);

    // Randomized messages over shuffled S tables; first run uses L=255
    for (int n = 0; n < 8; n++) begin
      set_identity();
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(a, 0);
        t = s_init[a];
        s_init[a] = s_init[r];
        s_init[r] = t;
      end
      len = (n == 0) ? 255 : int'($urandom_range(40, 1));
      clear_ct();
      ct_init[0] = 8'(len);
      for (int b = 1; b <= len; b++) ct_init[b] = 8'($urandom);
      run_and_check(len, 1'b0, $sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prga.md
# prga

Pseudo-random generation stage of the ARC4 decrypt datapath, directly downstream of the key-scheduling stage. Once KSA has left a permuted S table in the 256×8 S memory, `prga` walks the length-prefixed ciphertext memory, keeps permuting S, and writes the length-prefixed plaintext memory (byte XOR with the keystream). It uses the same en/rdy start handshake and external single-port synchronous-RAM ports as the init and KSA stages.

## Interface
Parameters: none; widths are fixed by the ARC4 byte/256-entry format.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `en` in 1: start request; accepted only when `rdy`=1.
- `rdy` out 1: idle/ready; 1 only in IDLE.
- `s_addr` out 8: S memory address.
- `s_rddata` in 8: S read data.
- `s_wrdata` out 8: S write data.
- `s_wren` out 1: S write enable.
- `ct_addr` out 8: ciphertext memory address (read-only).
- `ct_rddata` in 8: ciphertext read data.
- `pt_addr` out 8: plaintext memory address.
- `pt_wrdata` out 8: plaintext write data.
- `pt_wren` out 1: plaintext write enable.

## Operation
- Memory model: address/wren driven in cycle N; `*_rddata` valid in cycle N+1 and sampled at the end of N+1. Writes commit at the end of the cycle in which `wren`=1.
- Byte 0 of ct is the length L (0..255). pt[0] is written with L; bytes 1..L are message bytes.
- Algorithm: i=0, j=0; for k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pt[k]=ct[k] ^ S[S[i]+S[j]]. All sums are mod 256 (8-bit wrap; carry discarded).
- Registers: i, j, k, len, si, sj (all 8 bits).
- States and transitions:
  - IDLE: `rdy`=1. `en`=1 goes to LEN_A. `en`=0 stays in IDLE.
  - LEN_A: `ct_addr`=0.
  - LEN_D: len<=`ct_rddata`. Write pt[0]=`ct_rddata`. i<=1, j<=0, k<=1. If `ct_rddata`==0 go to DONE, else go to RD_I.
  - RD_I: `s_addr`=i.
  - RD_J: si<=`s_rddata`. j<=j+`s_rddata`. `s_addr`=j+`s_rddata` (combinational).
  - WR_I: sj<=`s_rddata`. Write S[i]=`s_rddata`.
  - WR_J: write S[j]=si. `ct_addr`=k.
  - RD_P: `s_addr`=si+sj. `ct_addr`=k (held).
  - WR_P: write pt[k]=`s_rddata` ^ `ct_rddata`. If k==len go to DONE; else k<=k+1, i<=i+1, go to RD_I.
  - DONE: all wren=0. Go to IDLE.
- i==j is legal. The swap writes the same value twice, and the pad index is unchanged because the swap preserves si+sj.
- L=255 is legal. k compares against len before incrementing, so k never wraps.
- `en` is ignored while not in IDLE. It is level-sampled in IDLE only.
- Reset mid-operation: the block aborts immediately to IDLE. No further writes occur. Memory contents are left partially updated.

## Timing
- Reset values: `rdy`=1 (IDLE). All addresses, wrdata and wren are 0. i, j, k, len, si, sj are 0.
- Outside the states listed above, all `*_wren` are 0 and addresses/wrdata are 0.
- Per message byte: 6 cycles (RD_I..WR_P).
- `rdy` is low for 3+6L cycles after the accepting edge. For L=0 this is 3 cycles.
- Exactly one S write occurs in each of WR_I and WR_J. Exactly one pt write occurs per byte in WR_P, plus one in LEN_D.
- No combinational path from `en` to any output other than through state.

## Structure
- Package `arc4_pkg` holds:
  - the `prga_state_t` enum;
  - `ARC4_MEM_DEPTH`=256 and `ARC4_BYTE_W`=8, shared with init/KSA.
- Single flat FSM+datapath module; no sub-module is warranted.
- Memories are external. The top level (task3) muxes the S port between init, KSA and `prga` by sequencing their en/rdy.

## Test plan
- Reset mid-run: assert `rst` during WR_I of byte 1 -> `rdy`=1 and all wren=0 immediately; no further writes.
- Identity S, ct = {01, 00} -> pt[0]=01, pt[1]=02. S[1..2] unchanged. `rdy` returns 9 cycles after accept.
- Identity S, ct = {02, 00, 00} -> pt = {02, 02, 05}. Afterwards S[2]=03, S[3]=02.
- S preloaded with KSA("Key"=0x4B6579), ct = {09, BB F3 16 E8 D9 40 AF 0A D3} -> pt = {09, 50 6C 61 69 6E 74 65 78 74} ("Plaintext").
- L=0: ct[0]=00 -> only pt[0]=00 written, no S writes, `rdy` back after 3 cycles. `en` held high during busy is ignored; the block restarts only from IDLE.
